fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 19 +
 rtl/rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Definitions shared by sync_fifo and the blocks that feed it.
//
//   arb_state_e    : write-arbiter FSM encoding (IDLE=0, GRANT=1)
//   MAX_BURST_DEF  : default number of beats per grant tenure
//   BURST_CNT_W    : width of the beat counter; covers bursts of 1..15
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_CNT_W   = 4;

endpackage : fifo_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches the request vector starting
//   at last_owner_i+1 (mod NREQ) and returns the first set requester.
//
//   Ports
//     req_i        [NREQ-1:0]  request vector
//     last_owner_i [OWN_W-1:0] requester granted most recently
//     valid_o                  at least one request is set
//     idx_o        [OWN_W-1:0] selected requester (0 when valid_o is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int OWN_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [OWN_W-1:0] last_owner_i,
    output logic             valid_o,
    output logic [OWN_W-1:0] idx_o
);

    logic [OWN_W-1:0] cand;

    // Walk the search order backwards so the candidate closest to
    // last_owner_i+1 is the last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = OWN_W'((int'(last_owner_i) + i) % NREQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one sync_fifo write port among NREQ requesters. A requester is
//   picked round-robin while IDLE (one cycle of arbitration latency), then
//   owns the port for up to MAX_BURST beats. The tenure ends early when the
//   owner drops its request. A full FIFO stalls the tenure without losing
//   the owner or the beat count, and never produces a write.
//
//   Ports
//     clk_i          clock, all state on rising edge
//     rst_n_i        asynchronous active-low reset
//     req_i          [NREQ-1:0]        per-requester write request
//     wdata_i        [NREQ*WIDTH-1:0]  requester k data at [k*WIDTH +: WIDTH]
//     gnt_o          [NREQ-1:0]        per-requester ready
//     fifo_full_i    FIFO full flag
//     fifo_wr_en_o   FIFO write enable
//     fifo_wdata_o   [WIDTH-1:0]       FIFO write data (owner's slice)
//     owner_o        [OWN_W-1:0]       current or last grant owner
//     busy_o         high while in GRANT
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int OWN_W     = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    output logic [NREQ-1:0]       gnt_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [WIDTH-1:0]      fifo_wdata_o,
    output logic [OWN_W-1:0]      owner_o,
    output logic                  busy_o
);

    arb_state_e              state_q, state_d;
    logic [OWN_W-1:0]        owner_q, owner_d;
    logic [OWN_W-1:0]        last_owner_q, last_owner_d;
    logic [BURST_CNT_W-1:0]  cnt_q, cnt_d;
    logic [BURST_CNT_W-1:0]  cnt_inc;
    logic                    beat;
    logic                    pick_valid;
    logic [OWN_W-1:0]        pick_idx;
    logic [WIDTH-1:0]        slice [NREQ];

    rr_pick #(
        .NREQ  (NREQ),
        .OWN_W (OWN_W)
    ) u_rr_pick (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .valid_o      (pick_valid),
        .idx_o        (pick_idx)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = wdata_i[g*WIDTH +: WIDTH];
    end

    assign cnt_inc = cnt_q + BURST_CNT_W'(1);

    // last_owner resets to NREQ-1 so the first search starts at requester 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= OWN_W'(NREQ - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        gnt_o        = '0;
        beat         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A full FIFO blocks selection so the rotation is not
                // advanced for a tenure that could not write anyway.
                if (pick_valid && !fifo_full_i) begin
                    state_d      = ST_GRANT;
                    owner_d      = pick_idx;
                    last_owner_d = pick_idx;
                    cnt_d        = '0;
                end
            end

            ST_GRANT: begin
                gnt_o[owner_q] = ~fifo_full_i;
                beat           = req_i[owner_q] & ~fifo_full_i;
                // A dropped request ends the tenure even during a full stall;
                // otherwise a full FIFO simply holds owner, count and state.
                if (!req_i[owner_q]) begin
                    state_d = ST_IDLE;
                end else if (beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BURST_CNT_W'(MAX_BURST)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_wr_en_o = beat;
    assign fifo_wdata_o = slice[owner_q];
    assign owner_o      = owner_q;
    assign busy_o       = (state_q == ST_GRANT);

endmodule : fifo_wr_arbiter
